// File: rtl/hog_bin_if.sv
// Bin stream handshake between the HOG bin reader and
// the block-normalisation stage.
interface hog_bin_if #(
  parameter int BIN_W = 14
) ();
  logic             bin_valid;
  logic             bin_ready;
  logic [BIN_W-1:0] bin_data;
  logic [3:0]       bin_idx;
  logic             bin_last;

  modport master (
    output bin_valid,
    output bin_data,
    output bin_idx,
    output bin_last,
    input  bin_ready
  );

  modport slave (
    input  bin_valid,
    input  bin_data,
    input  bin_idx,
    input  bin_last,
    output bin_ready
  );
endinterface

// File: rtl/hog_bin_reader.sv
// Snapshots nine HOG bins on capture, streams them one per
// beat, then publishes the cell's L1 sum.
module hog_bin_reader #(
  parameter int BIN_W = 14,
  parameter int SUM_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [BIN_W-1:0] H_0,
  input  logic [BIN_W-1:0] H_1,
  input  logic [BIN_W-1:0] H_2,
  input  logic [BIN_W-1:0] H_3,
  input  logic [BIN_W-1:0] H_4,
  input  logic [BIN_W-1:0] H_5,
  input  logic [BIN_W-1:0] H_6,
  input  logic [BIN_W-1:0] H_7,
  input  logic [BIN_W-1:0] H_8,
  output logic             cap_ready,
  hog_bin_if.master        bin,
  output logic [SUM_W-1:0] cell_sum,
  output logic             sum_valid,
  output logic             overrun,
  input  logic             clear_overrun
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t           state_q;
  logic [BIN_W-1:0] shadow_q [9];
  logic [BIN_W-1:0] h_w [9];
  logic [3:0]       idx_q;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] sum_q;
  logic             sum_valid_q;
  logic             ovr_q;
  logic             ovr_d;
  logic             stream;
  logic             hs;
  logic [BIN_W-1:0] cur;

  assign h_w[0] = H_0;
  assign h_w[1] = H_1;
  assign h_w[2] = H_2;
  assign h_w[3] = H_3;
  assign h_w[4] = H_4;
  assign h_w[5] = H_5;
  assign h_w[6] = H_6;
  assign h_w[7] = H_7;
  assign h_w[8] = H_8;

  assign stream    = (state_q == STREAM);
  assign cap_ready = !stream;
  assign cur       = shadow_q[idx_q];
  assign hs        = stream && bin.bin_ready;

  // idx_q lingers at 8 after a cell, so mask beat fields in IDLE
  assign bin.bin_valid = stream;
  assign bin.bin_data  = stream ? cur : '0;
  assign bin.bin_idx   = stream ? idx_q : 4'd0;
  assign bin.bin_last  = stream && (idx_q == 4'd8);

  assign cell_sum  = sum_q;
  assign sum_valid = sum_valid_q;
  assign overrun   = ovr_q;

  // set beats clear when both happen in one cycle
  always_comb begin
    ovr_d = ovr_q;
    if (clear_overrun) ovr_d = 1'b0;
    if (capture && stream) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      sum_valid_q <= 1'b0;
      ovr_q       <= ovr_d;
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < 9; i++) begin
              shadow_q[i] <= h_w[i];
            end
            idx_q   <= 4'd0;
            acc_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            if (idx_q == 4'd8) begin
              sum_q       <= acc_q + SUM_W'(cur);
              sum_valid_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              acc_q <= acc_q + SUM_W'(cur);
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
